mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 12, address width in words.
REQ-002 Parameter: DW, 16, data width.
REQ-003 Parameter: LOCK_MAX, 4, max consecutive grants one locked owner may hold while the other port waits (range 1..15).
REQ-004 Port: clk  in  1  single clock, all state on rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port: reqN  in  1  (N=0,1) port N requests one memory access this cycle.
REQ-007 Port: weN  in  1  access is a write when 1, read when 0.
REQ-008 Port: addrN  in  AW  word address of access.
REQ-009 Port: wdataN  in  DW  write data.
REQ-010 Port: lockN  in  1  port N wants to keep ownership after this access (read-modify-write).
REQ-011 Port: gntN  out  1  access of port N is driven to memory this cycle.
REQ-012 Port: rdataN  out  DW  registered read data for port N.
REQ-013 Port: rvalidN  out  1  rdataN valid, one-cycle pulse.
REQ-014 Port: mem_addr  out  AW  memory address.
REQ-015 Port: mem_we  out  1  memory write enable; memory commits at the rising edge.
REQ-016 Port: mem_wdata  out  DW  memory write data.
REQ-017 Port: mem_rdata  in  DW  memory read data, combinational from mem_addr.

Function
REQ-018 One access per cycle; gnt0 and gnt1 SHALL never be high together.
REQ-019 gntN SHALL be combinational from registered state and current req inputs; no grant without reqN.
REQ-020 Granted port's addr/we/wdata SHALL drive mem_*; with no grant mem_we=0, mem_addr=0, mem_wdata=0.
REQ-021 Read grant: mem_rdata captured into rdataN at the grant edge; rvalidN high the following cycle only; rdataN holds until the next read by port N.
REQ-022 Write grant: rvalidN stays 0, rdataN unchanged.
REQ-023 States: IDLE (no owner), OWN0, OWN1; registered, plus last-grant pointer and 4-bit hold counter.
REQ-024 IDLE: one requester -> it is granted; both -> port that is not the last grantee is granted (round-robin).
REQ-025 Any grant with lockN=1 SHALL move to OWNN (hold counter=1); with lockN=0 to IDLE.
REQ-026 OWNN: reqN=1 and (other port idle or hold<LOCK_MAX) -> port N granted, hold increments (saturating at 15); stays OWNN while lockN=1, else IDLE.
REQ-027 OWNN with other port requesting and hold=LOCK_MAX -> other port granted (forced handover), ownership per REQ-025 for that port.
REQ-028 OWNN with reqN=0 -> ownership released, arbitrate as IDLE in the same cycle.
REQ-029 Last-grant pointer updates on every grant.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, last-grant=1 (port 0 wins first tie), hold=0, rvalid0/1=0, rdata0/1=0.
REQ-031 gnt0/1 and mem_we SHALL be 0 while rst_n low, regardless of req.
REQ-032 Reset during a locked sequence SHALL discard ownership; no pending rvalid after release.
REQ-033 Deassertion of rst_n takes effect at the next rising clk edge.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum (IDLE, OWN0, OWN1) and port index constants.
REQ-035 Sub-module rr_pick2 SHALL implement the 2-way round-robin choice (req0, req1, last -> pick, valid).

Verification
REQ-036 After reset, req0=req1=1, we=0, addr0=0x010, addr1=0x020 -> gnt0 cycle 1, gnt1 cycle 2, alternating; rvalid0 with memory[0x010] one cycle after gnt0.
REQ-037 Port 1 write addr 0x005 data 0xBEEF, then port 0 read 0x005 -> rdata0=0xBEEF, rvalid0 pulse one cycle after gnt0.
REQ-038 LOCK_MAX=4, port 0 lock=1 continuous, port 1 requesting -> gnt0 4 consecutive cycles, then gnt1, no overlap.
REQ-039 Port 0 locked, req0 drops while req1=1 -> gnt1 same cycle, state IDLE or OWN1 per lock1.
REQ-040 rst_n pulsed low mid-lock asynchronously -> gnt0/1, mem_we, rvalid0/1 drop immediately; first tie after reset goes to port 0.
REQ-041 Random req/we/lock for 10k cycles vs. reference model -> never dual grant, every rvalid data matches model memory.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter: ownership states,
// port indices and the hold-counter helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int         HOLD_W   = 4;
    localparam logic [3:0] HOLD_SAT = 4'd15;

    // The hold counter saturates instead of wrapping, so a long solo lock never
    // looks like a fresh one.
    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] h);
        return (h == HOLD_SAT) ? h : h + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin chooser: on a tie the port that was not granted last wins,
// otherwise the single requester wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick,
    output logic valid
);

    assign valid = req0 | req1;
    assign pick  = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter with round-robin sharing and bounded lock
// ownership for read-modify-write sequences. Grants are combinational.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 12,
    parameter int DW       = 16,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          lock0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output arb_state_e    state
);

    localparam logic [HOLD_W-1:0] LOCK_LIM = HOLD_W'(LOCK_MAX);

    arb_state_e        cur, nxt;
    logic              last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic rr_pick, rr_valid;
    logic grant_v, grant_p, keep, g_lock;

    rr_pick2 u_rr (
        .req0  (req0),
        .req1  (req1),
        .last  (last_q),
        .pick  (rr_pick),
        .valid (rr_valid)
    );

    // Grant selection. keep marks the owner continuing its lock, which is the
    // only case where the hold counter increments rather than restarting.
    always_comb begin
        grant_v = 1'b0;
        grant_p = PORT0;
        keep    = 1'b0;
        case (cur)
            OWN0: begin
                if (req0) begin
                    grant_v = 1'b1;
                    if (req1 && (hold_q >= LOCK_LIM)) begin
                        grant_p = PORT1;
                    end else begin
                        grant_p = PORT0;
                        keep    = 1'b1;
                    end
                end else begin
                    grant_v = rr_valid;
                    grant_p = rr_pick;
                end
            end
            OWN1: begin
                if (req1) begin
                    grant_v = 1'b1;
                    if (req0 && (hold_q >= LOCK_LIM)) begin
                        grant_p = PORT0;
                    end else begin
                        grant_p = PORT1;
                        keep    = 1'b1;
                    end
                end else begin
                    grant_v = rr_valid;
                    grant_p = rr_pick;
                end
            end
            default: begin
                grant_v = rr_valid;
                grant_p = rr_pick;
            end
        endcase
        // No grant may escape while reset is held, whatever the request inputs.
        if (!rst_n) begin
            grant_v = 1'b0;
            keep    = 1'b0;
        end
    end

    always_comb begin
        nxt    = IDLE;
        hold_d = '0;
        last_d = last_q;
        g_lock = grant_p ? lock1 : lock0;
        if (grant_v) begin
            last_d = grant_p;
            if (g_lock) begin
                nxt    = grant_p ? OWN1 : OWN0;
                hold_d = keep ? hold_inc(hold_q) : 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= IDLE;
            last_q <= PORT1;
            hold_q <= '0;
        end else begin
            cur    <= nxt;
            last_q <= last_d;
            hold_q <= hold_d;
        end
    end

    assign gnt0  = grant_v & (grant_p == PORT0);
    assign gnt1  = grant_v & (grant_p == PORT1);
    assign state = cur;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_we    = we0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_we    = we1;
            mem_wdata = wdata1;
        end
    end

    // Read data is captured at the grant edge and held until the port's next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0) rdata0 <= mem_rdata;
            if (gnt1 && !we1) rdata1 <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked against a queue/array reference model of the arbitration rules.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW       = 12;
    localparam int DW       = 16;
    localparam int LOCK_MAX = 4;
    localparam int DEPTH    = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, lock0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    arb_state_e    state;

    mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .state(state)
    );

    // ---------------- clock and memory ----------------
    always #5 clk = ~clk;

    logic [DW-1:0] mem       [DEPTH];
    logic [DW-1:0] model_mem [DEPTH];

    assign mem_rdata = mem[mem_addr];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]       = DW'($urandom);
            model_mem[i] = mem[i];
        end
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_owner;   // -1 none, else owning port
    int            m_count;   // consecutive grants held by the owner
    int            m_last;
    logic          m_rv [2];
    logic [DW-1:0] m_rd [2];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    logic          obs_g0, obs_g1;

    function automatic arb_state_e owner_enc(input int o);
        if (o == 0) return OWN0;
        if (o == 1) return OWN1;
        return IDLE;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_count = 0;
        m_last  = 1;
        m_rv    = '{1'b0, 1'b0};
        m_rd    = '{'0, '0};
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic l0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d1, input logic l1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // One clock cycle: apply inputs, check last edge's results and this cycle's
    // grant against the model, then advance the model past the coming edge.
    task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input logic l0,
                        input logic r1, input logic w1, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d1, input logic l1);
        logic          r [2];
        logic          w [2];
        logic          l [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        int            g;
        bit            cont;
        r = '{r0, r1}; w = '{w0, w1}; l = '{l0, l1}; a = '{a0, a1}; d = '{d0, d1};
        @(negedge clk);
        drive(r0, w0, a0, d0, l0, r1, w1, a1, d1, l1);
        #1;
        check("rvalid0", 32'(rvalid0), 32'(m_rv[0]));
        check("rvalid1", 32'(rvalid1), 32'(m_rv[1]));
        if (rvalid0) begin
            if (exp_q0.size() == 0) check("rvalid0_unexpected", 32'd1, 32'd0);
            else check("rdata0_on_valid", 32'(rdata0), 32'(exp_q0.pop_front()));
        end
        if (rvalid1) begin
            if (exp_q1.size() == 0) check("rvalid1_unexpected", 32'd1, 32'd0);
            else check("rdata1_on_valid", 32'(rdata1), 32'(exp_q1.pop_front()));
        end
        check("rdata0_hold", 32'(rdata0), 32'(m_rd[0]));
        check("rdata1_hold", 32'(rdata1), 32'(m_rd[1]));
        check("state", 32'(state), 32'(owner_enc(m_owner)));

        g    = -1;
        cont = 1'b0;
        if (m_owner >= 0 && r[m_owner]) begin
            if (r[1-m_owner] && m_count >= LOCK_MAX) g = 1 - m_owner;
            else begin
                g    = m_owner;
                cont = 1'b1;
            end
        end else if (r[0] && r[1]) g = 1 - m_last;
        else if (r[0]) g = 0;
        else if (r[1]) g = 1;

        obs_g0 = gnt0;
        obs_g1 = gnt1;
        check("dual_gnt", 32'(gnt0 & gnt1), 32'd0);
        check("gnt0", 32'(gnt0), 32'(g == 0));
        check("gnt1", 32'(gnt1), 32'(g == 1));
        check("mem_we", 32'(mem_we), (g >= 0) ? 32'(w[g]) : 32'd0);
        check("mem_addr", 32'(mem_addr), (g >= 0) ? 32'(a[g]) : 32'd0);
        check("mem_wdata", 32'(mem_wdata), (g >= 0) ? 32'(d[g]) : 32'd0);

        m_rv = '{1'b0, 1'b0};
        if (g >= 0) begin
            m_last = g;
            if (w[g]) model_mem[a[g]] = d[g];
            else begin
                m_rv[g] = 1'b1;
                m_rd[g] = model_mem[a[g]];
                if (g == 0) exp_q0.push_back(m_rd[g]);
                else exp_q1.push_back(m_rd[g]);
            end
            if (l[g]) begin
                m_count = cont ? ((m_count < 15) ? m_count + 1 : 15) : 1;
                m_owner = g;
            end else begin
                m_owner = -1;
                m_count = 0;
            end
        end else begin
            m_owner = -1;
            m_count = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [4:0] seq;

    initial begin
        rst_n = 1'b0;
        model_reset();
        drive(1'b1, 1'b1, 12'h010, 16'h1111, 1'b1, 1'b1, 1'b1, 12'h020, 16'h2222, 1'b1);
        #2;
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rvalid1", 32'(rvalid1), 32'd0);
        check("rst_rdata0", 32'(rdata0), 32'd0);
        check("rst_rdata1", 32'(rdata1), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
        repeat (2) @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // Round-robin tie with reads on both ports.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b1, 1'b0, 12'h020, '0, 1'b0);
            check("rr_alternate_gnt0", 32'(obs_g0), 32'((i % 2) == 0));
        end
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        // Write from port 1, read back on port 0.
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 12'h005, 16'hBEEF, 1'b0);
        step(1'b1, 1'b0, 12'h005, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("wr_rd_gnt0", 32'(obs_g0), 32'd1);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("wr_rd_rvalid0", 32'(rvalid0), 32'd1);
        check("wr_rd_rdata0", 32'(rdata0), 32'hBEEF);

        // Lock limit: port 0 holds LOCK_MAX grants, then port 1 is forced in.
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 12'h030, '0, 1'b0);
        seq = '0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 12'h040, '0, 1'b1, 1'b1, 1'b0, 12'h041, '0, 1'b0);
            seq = {seq[3:0], obs_g0};
        end
        check("lock_max_seq", 32'(seq), 32'b11110);

        // Owner drops its request: the other port is granted in the same cycle.
        step(1'b1, 1'b1, 12'h050, 16'h0A0A, 1'b1, 1'b1, 1'b0, 12'h051, '0, 1'b0);
        check("drop_setup_gnt0", 32'(obs_g0), 32'd1);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 12'h052, '0, 1'b1);
        check("drop_gnt1", 32'(obs_g1), 32'd1);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("drop_state_own1", 32'(state), 32'(OWN1));

        // Asynchronous reset in the middle of a locked sequence.
        step(1'b1, 1'b0, 12'h060, '0, 1'b1, 1'b1, 1'b0, 12'h061, '0, 1'b0);
        step(1'b1, 1'b0, 12'h062, '0, 1'b1, 1'b1, 1'b0, 12'h063, '0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        we0   = 1'b1;
        #1;
        check("midlock_rst_gnt0", 32'(gnt0), 32'd0);
        check("midlock_rst_gnt1", 32'(gnt1), 32'd0);
        check("midlock_rst_mem_we", 32'(mem_we), 32'd0);
        check("midlock_rst_rvalid0", 32'(rvalid0), 32'd0);
        check("midlock_rst_rvalid1", 32'(rvalid1), 32'd0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 12'h070, '0, 1'b0, 1'b1, 1'b0, 12'h071, '0, 1'b0);
        check("post_rst_tie_gnt0", 32'(obs_g0), 32'd1);

        // Random traffic over a small address window to force collisions.
        for (int i = 0; i < 10000; i++) begin
            int lock_bias;
            lock_bias = (i < 5000) ? 1 : 3;
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 15)), DW'($urandom),
                 $urandom_range(0, 3) < lock_bias,
                 $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 15)), DW'($urandom),
                 $urandom_range(0, 3) < lock_bias);
        end
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
        check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
